irq_sequencer: RTL
==================

// Module: irq_sequencer
// PURPOSE
//   Sequences external interrupt requests into the IRQ input of the CPU control unit.
//   Per-source rising-edge capture, a software mask, fixed priority (lowest index wins) and
//   single-cycle IRQ issue. No nested interrupts: blocks new IRQs until the ISR exits.
//   Sits between the peripherals and Control; the datapath supplies kernel-mode and ISR-exit status.
// PARAMETERS
//   NUM_SRC     8          number of interrupt sources (1..16)
//   ID_W        4          width of irq_cause; must satisfy 2**ID_W >= NUM_SRC
//   MASK_RESET  {NUM_SRC{1'b1}}  mask value after reset (1 = enabled)
//   TIMEOUT     1024       ISR watchdog limit in cycles (used only with IRQ_TIMEOUT_EN)
// PORTS
//   clk          in   1        system clock
//   reset        in   1        synchronous, active-high reset
//   irq_src      in   NUM_SRC  level request lines from peripherals, synchronous to clk
//   mask_we      in   1        write enable for the mask register
//   mask_wdata   in   NUM_SRC  new mask value
//   mask_rdata   out  NUM_SRC  current mask register
//   kernel_mode  in   1        PC[31]; 1 = executing supervisor code
//   stall        in   1        datapath cannot accept a redirect this cycle
//   isr_exit     in   1        one-cycle pulse: ISR return (jr $k0 issued in kernel mode)
//   irq          out  1        to Control IRQ input; high exactly one cycle per taken IRQ
//   irq_cause    out  ID_W     index of the source being serviced; held until next take
//   irq_ack      out  NUM_SRC  one-hot pulse to the serviced source, coincident with irq
//   busy         out  1        high in TAKE and ISR states
//   isr_timeout  out  1        one-cycle watchdog pulse (0 when IRQ_TIMEOUT_EN is undefined)
// BEHAVIOUR
//   Reset: irq=0, irq_ack=0, irq_cause=0, busy=0, isr_timeout=0, pending=0, prev_src=0,
//     mask=MASK_RESET, state=IDLE. Reset in any state (including ISR) returns to IDLE and discards pending.
//   Edge capture: prev_src<=irq_src each cycle; pending[i] set when irq_src[i]&~prev_src[i].
//     A level held high is captured once. Set wins over the clear of the same bit in the same cycle.
//   Mask: mask_we writes at clock edge; effective next cycle. Masked sources still latch pending.
//   eligible = pending & mask; selected = lowest set index of eligible.
//   FSM (registered outputs):
//     IDLE -> TAKE when |eligible & ~kernel_mode & ~stall; latch irq_cause=selected.
//     TAKE (1 cycle): irq=1, irq_ack[cause]=1, busy=1; clear pending[cause]; -> ISR.
//     ISR: busy=1; on isr_exit & kernel_mode -> IDLE. isr_exit without kernel_mode is ignored.
//     isr_exit in IDLE/TAKE is ignored.
//   Latency: rising edge sampled at clock edge k -> pending at k; TAKE entered at k+1 ->
//     irq visible in the cycle after edge k+1 (2 cycles from request, no stall).
//   Stall or kernel_mode high in IDLE: hold IDLE, keep pending; no request is lost.
//   Simultaneous requests: the lowest index is taken; others stay pending and are taken
//     after isr_exit (1 IDLE cycle between ISR and the next TAKE).
//   Mask cleared while pending: no TAKE; re-enabling the mask releases the pending request.
// CONFIGURATION
//   IRQ_TIMEOUT_EN defined: counter clears on ISR entry and increments every ISR cycle; at count
//     TIMEOUT-1 without isr_exit -> isr_timeout=1 for one cycle, state->IDLE. isr_exit wins
//     over a timeout in the same cycle (isr_timeout stays 0).
//   IRQ_TIMEOUT_EN undefined: no counter; isr_timeout tied to 0; ISR is left only via isr_exit.
// TESTING
//   reset; irq_src[3] 0->1 (held) -> irq=1 exactly one cycle, 2 cycles later; cause=3; ack=8'h08; no retake while held.
//   irq_src=8'h24 rising together -> cause=2 first; pulse isr_exit -> after 1 IDLE cycle cause=5.
//   mask=8'hFE, rise src0 -> no irq; write mask=8'hFF -> irq cause=0 on the following TAKE.
//   kernel_mode=1 or stall=1 held 5 cycles with src1 pending -> irq=0; deassert -> irq, cause=1.
//   in ISR with src4 pending, assert reset -> all outputs 0, mask=MASK_RESET; no irq afterwards.
//   IRQ_TIMEOUT_EN, TIMEOUT=16, no isr_exit -> isr_timeout pulse 16 cycles after ISR entry, busy=0.

Source files
------------

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: per-source rising-edge capture, software mask, fixed priority (lowest index)
// and a single-cycle IRQ issue with no nesting. Optional ISR watchdog enabled by macro IRQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an eligible request while in user mode and not stalled
// TAKE  | one cycle: irq/irq_ack asserted, serviced pending bit cleared
// ISR   | handler running; new requests only accumulate as pending
module irq_sequencer #(
  parameter int                 NUM_SRC    = 8,
  parameter int                 ID_W       = 4,
  parameter logic [NUM_SRC-1:0] MASK_RESET = {NUM_SRC{1'b1}},
  parameter int                 TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_rdata,
  input  logic               kernel_mode,
  input  logic               stall,
  input  logic               isr_exit,
  output logic               irq,
  output logic [ID_W-1:0]    irq_cause,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic               busy,
  output logic               isr_timeout
);

  typedef enum logic [1:0] {IDLE, TAKE, ISR} state_t;

  if ((2 ** ID_W) < NUM_SRC || NUM_SRC < 1 || NUM_SRC > 16 || TIMEOUT < 2) begin : g_bad_cfg
    $error("irq_sequencer: illegal parameter combination");
  end

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] prev_src;
  logic [NUM_SRC-1:0] pending, pending_nx;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_bit;
  logic [ID_W-1:0]    sel;
  logic               timeout_hit;

`ifdef IRQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] tmr_cnt;
`endif

  assign mask_rdata = mask;

  always_comb begin
    eligible    = pending & mask;
    sel         = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end

    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if ((|eligible) && !kernel_mode && !stall) state_nx = TAKE;
      TAKE: state_nx = ISR;
      ISR: begin
        if (isr_exit && kernel_mode) begin
          state_nx = IDLE;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (tmr_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase

    // A new rising edge on the serviced source wins over its clear.
    clr_bit    = (state == TAKE) ? (NUM_SRC'(1) << irq_cause) : '0;
    pending_nx = (pending & ~clr_bit) | (irq_src & ~prev_src);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prev_src    <= '0;
      pending     <= '0;
      mask        <= MASK_RESET;
      irq         <= 1'b0;
      irq_cause   <= '0;
      irq_ack     <= '0;
      busy        <= 1'b0;
      isr_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      prev_src    <= irq_src;
      pending     <= pending_nx;
      if (mask_we) mask <= mask_wdata;
      irq         <= (state_nx == TAKE);
      irq_ack     <= (state_nx == TAKE) ? (NUM_SRC'(1) << sel) : '0;
      if (state == IDLE && state_nx == TAKE) irq_cause <= sel;
      busy        <= (state_nx != IDLE);
      isr_timeout <= timeout_hit;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_cnt <= '0;
    end else if (state != ISR) begin
      tmr_cnt <= '0;
    end else begin
      tmr_cnt <= tmr_cnt + 1'b1;
    end
  end
`endif

endmodule
